// File: rtl/camera_stream_capture_pkg.sv
// Shared types for the camera capture block: FSM state encoding, FIFO word
// layout and the filler word that closes a broken packet.
package cam_capture_pkg;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    ACTIVE     = 2'd1,
    DROP       = 2'd2,
    DONE       = 2'd3
  } cap_state_t;

  // Sized for the widest supported pixel; narrower builds use the low bits.
  localparam int CAP_DATA_W = 16;

  typedef struct packed {
    logic                  sop;
    logic                  eop;
    logic [CAP_DATA_W-1:0] data;
  } cap_word_t;

  localparam cap_word_t FILLER_WORD = '{sop: 1'b0, eop: 1'b1, data: '0};

endpackage

// File: rtl/camera_stream_capture_if.sv
// Avalon-ST video stream between the capture block (master) and the VIP sink.
interface camera_stream_capture_if #(
  parameter int DATA_W = 12
) ();
  logic [DATA_W-1:0] st_data;
  logic              st_valid;
  logic              st_sop;
  logic              st_eop;
  logic              st_ready;

  modport master (output st_data, st_valid, st_sop, st_eop, input st_ready);
  modport slave  (input st_data, st_valid, st_sop, st_eop, output st_ready);
endinterface

// File: rtl/camera_stream_capture_fifo.sv
// Synchronous show-ahead FIFO, depth 2^AW; a write while full is accepted
// only when a read frees the slot in the same cycle.
module cap_sync_fifo #(
  parameter int W  = 14,
  parameter int AW = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [0:(1<<AW)-1];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_wr;
  logic         do_rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/camera_stream_capture.sv
// Raw FVAL/LVAL sensor stream to Avalon-ST video packets: window crop,
// power-of-two decimation, elastic FIFO and overflow/short-frame recovery.
//
// state      | meaning
// WAIT_FRAME | idle, config latched on the next enabled FVAL rise
// ACTIVE     | writing kept window pixels
// DROP       | packet broken; push one filler EOP, then wait for FVAL low
// DONE       | EOP written; wait for FVAL low
module camera_stream_capture
  import cam_capture_pkg::*;
#(
  parameter int DATA_W  = 12,
  parameter int CNT_W   = 12,
  parameter int FIFO_AW = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [DATA_W-1:0]       cam_data,
  input  logic                    cam_fval,
  input  logic                    cam_lval,
  input  logic [CNT_W-1:0]        cfg_x0,
  input  logic [CNT_W-1:0]        cfg_y0,
  input  logic [CNT_W-1:0]        cfg_w,
  input  logic [CNT_W-1:0]        cfg_h,
  input  logic [1:0]              cfg_decim,
  camera_stream_capture_if.master st,
  input  logic                    clear_status,
  output logic                    overflow,
  output logic                    short_frame,
  output logic [15:0]             frame_count
);
  logic [DATA_W-1:0] data_q;
  logic fval_q, fval_p, lval_q, lval_p;
  logic fval_rise, fval_fall, lval_rise, lval_fall;
  logic [CNT_W-1:0] x_q, y_q, x_cur, y_cur;
  logic [CNT_W-1:0] x0_q, y0_q, w_q, h_q;
  logic [1:0]       d_q;
  logic [CNT_W:0]   step, x_end, y_end;
  logic [CNT_W-1:0] mask, dx, dy;
  logic in_x, in_y, on_grid, last_px, keep;
  cap_state_t state_q, state_d;
  logic wrote_q, need_fill_q;
  logic push, push_sop, push_eop, set_ovf, set_short, can_push, pop;
  logic [DATA_W-1:0] push_data;
  logic [DATA_W+1:0] rd_word;
  logic fifo_full, fifo_empty;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // fval copies reset high so a reset mid-frame cannot fake an FVAL rise.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q <= '0;
      fval_q <= 1'b1;
      fval_p <= 1'b1;
      lval_q <= 1'b0;
      lval_p <= 1'b0;
    end else begin
      data_q <= cam_data;
      fval_q <= cam_fval;
      fval_p <= fval_q;
      lval_q <= cam_lval;
      lval_p <= lval_q;
    end
  end

  assign fval_rise = fval_q && !fval_p;
  assign fval_fall = !fval_q && fval_p;
  assign lval_rise = lval_q && !lval_p;
  assign lval_fall = !lval_q && lval_p;
  assign x_cur     = lval_rise ? '0 : x_q;
  assign y_cur     = fval_rise ? '0 : y_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      if (lval_q) x_q <= sat_inc(x_cur);
      y_q <= lval_fall ? sat_inc(y_cur) : y_cur;
    end
  end

  assign step    = (CNT_W+1)'(1) << d_q;
  assign mask    = CNT_W'(step - 1'b1);
  assign x_end   = {1'b0, x0_q} + {1'b0, w_q};
  assign y_end   = {1'b0, y0_q} + {1'b0, h_q};
  assign dx      = x_cur - x0_q;
  assign dy      = y_cur - y0_q;
  assign in_x    = (x_cur >= x0_q) && ({1'b0, x_cur} < x_end);
  assign in_y    = (y_cur >= y0_q) && ({1'b0, y_cur} < y_end);
  assign on_grid = ((dx & mask) == '0) && ((dy & mask) == '0);
  assign last_px = ({1'b0, x_cur} == x_end - step) && ({1'b0, y_cur} == y_end - step);
  assign keep    = fval_q && lval_q && in_x && in_y && on_grid;

  assign pop      = !fifo_empty && st.st_ready;
  assign can_push = !fifo_full || pop;

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= WAIT_FRAME;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_FRAME: if (fval_rise && enable) state_d = ACTIVE;
      ACTIVE: begin
        if (fval_fall)      state_d = wrote_q ? DROP : WAIT_FRAME;
        else if (keep) begin
          if (!can_push)    state_d = DROP;
          else if (last_px) state_d = DONE;
        end
      end
      DROP: if ((!need_fill_q || can_push) && !fval_q) state_d = WAIT_FRAME;
      DONE: if (!fval_q) state_d = WAIT_FRAME;
      default: state_d = WAIT_FRAME;
    endcase
  end

  always_comb begin
    push      = 1'b0;
    push_sop  = FILLER_WORD.sop;
    push_eop  = FILLER_WORD.eop;
    push_data = FILLER_WORD.data[DATA_W-1:0];
    set_ovf   = 1'b0;
    set_short = 1'b0;
    case (state_q)
      ACTIVE: begin
        if (fval_fall) set_short = wrote_q;
        else if (keep) begin
          if (can_push) begin
            push      = 1'b1;
            push_sop  = !wrote_q;
            push_eop  = last_px;
            push_data = data_q;
          end else begin
            set_ovf = 1'b1;
          end
        end
      end
      DROP:    push = need_fill_q && can_push;
      default: push = 1'b0;
    endcase
  end

  // A filler is owed only if this frame already emitted its SOP.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x0_q <= '0; y0_q <= '0; w_q <= '0; h_q <= '0; d_q <= '0;
      wrote_q     <= 1'b0;
      need_fill_q <= 1'b0;
    end else if (state_q == WAIT_FRAME && state_d == ACTIVE) begin
      x0_q <= cfg_x0; y0_q <= cfg_y0; w_q <= cfg_w; h_q <= cfg_h; d_q <= cfg_decim;
      wrote_q     <= 1'b0;
      need_fill_q <= 1'b0;
    end else if (state_q == ACTIVE) begin
      if (push) wrote_q <= 1'b1;
      if (state_d == DROP) need_fill_q <= wrote_q;
    end else if (state_q == DROP && push) begin
      need_fill_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow    <= 1'b0;
      short_frame <= 1'b0;
      frame_count <= '0;
    end else begin
      overflow    <= set_ovf || (overflow && !clear_status);
      short_frame <= set_short || (short_frame && !clear_status);
      frame_count <= frame_count + 16'(push && push_eop);
    end
  end

  cap_sync_fifo #(.W(DATA_W + 2), .AW(FIFO_AW)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (push),
    .wr_data ({push_sop, push_eop, push_data}),
    .rd_en   (pop),
    .rd_data (rd_word),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign st.st_valid = !fifo_empty;
  assign st.st_data  = fifo_empty ? '0 : rd_word[DATA_W-1:0];
  assign st.st_sop   = !fifo_empty && rd_word[DATA_W+1];
  assign st.st_eop   = !fifo_empty && rd_word[DATA_W];
endmodule

// File: tb/tb_camera_stream_capture.sv
// Directed bench for camera_stream_capture: table of window/decimation
// vectors plus hand-written overflow, short-frame, latching and reset cases.
module tb_camera_stream_capture;
  logic        clk = 1'b0;
  logic        reset_n, enable, cam_fval, cam_lval, clear_status;
  logic [11:0] cam_data, cfg_x0, cfg_y0, cfg_w, cfg_h;
  logic [1:0]  cfg_decim;
  logic        overflow, short_frame;
  logic [15:0] frame_count;
  int          n_checks = 0;
  int          n_errors = 0;

  typedef struct {
    logic        sop;
    logic        eop;
    logic [11:0] data;
  } word_t;

  typedef struct {
    int cols, rows, x0, y0, w, h, d;
    int exp_words, exp_eop_data;
  } vec_t;

  word_t got[$];
  vec_t  vecs[6];

  camera_stream_capture_if #(.DATA_W(12)) st_bus ();

  camera_stream_capture #(.DATA_W(12), .CNT_W(12), .FIFO_AW(2)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .cam_data     (cam_data),
    .cam_fval     (cam_fval),
    .cam_lval     (cam_lval),
    .cfg_x0       (cfg_x0),
    .cfg_y0       (cfg_y0),
    .cfg_w        (cfg_w),
    .cfg_h        (cfg_h),
    .cfg_decim    (cfg_decim),
    .st           (st_bus),
    .clear_status (clear_status),
    .overflow     (overflow),
    .short_frame  (short_frame),
    .frame_count  (frame_count)
  );

  always #5 clk = ~clk;

  // Pops happen at posedge; record the accepted head word on the negedge before.
  always @(negedge clk)
    if (reset_n && st_bus.st_valid && st_bus.st_ready)
      got.push_back('{sop: st_bus.st_sop, eop: st_bus.st_eop, data: st_bus.st_data});

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_cfg(input int x0, input int y0, input int w, input int h, input int d);
    cfg_x0 = 12'(x0); cfg_y0 = 12'(y0); cfg_w = 12'(w); cfg_h = 12'(h); cfg_decim = 2'(d);
  endtask

  // Sends a frame of pixels data=y*64+x; FVAL drops early once 'cut' pixels are sent.
  task automatic frame(input int cols, input int rows, input int cut);
    int n = 0;
    tick();
    cam_fval = 1'b1;
    repeat (2) tick();
    for (int yy = 0; yy < rows; yy++) begin
      if (n >= cut) break;
      for (int xx = 0; xx < cols; xx++) begin
        if (n < cut) begin
          cam_lval = 1'b1;
          cam_data = 12'(yy * 64 + xx);
          tick();
          n++;
        end
      end
      cam_lval = 1'b0;
      cam_data = '0;
      repeat (2) tick();
    end
    cam_fval = 1'b0;
    repeat (3) tick();
  endtask

  task automatic compare_words(input string tag, input word_t e[$]);
    int bad;
    bad = (got.size() != e.size()) ? 1 : 0;
    for (int k = 0; k < got.size() && k < e.size(); k++)
      if (got[k].sop !== e[k].sop || got[k].eop !== e[k].eop || got[k].data !== e[k].data)
        bad++;
    check({tag, "_content"}, bad, 0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    word_t       e[$];
    logic [15:0] fc0;
    set_cfg(v.x0, v.y0, v.w, v.h, v.d);
    got.delete();
    fc0 = frame_count;
    frame(v.cols, v.rows, v.cols * v.rows);
    repeat (8) tick();
    for (int yy = v.y0; yy < v.y0 + v.h; yy += (1 << v.d))
      for (int xx = v.x0; xx < v.x0 + v.w; xx += (1 << v.d))
        e.push_back('{sop: (e.size() == 0), eop: 1'b0, data: 12'(yy * 64 + xx)});
    if (e.size() > 0) e[e.size()-1].eop = 1'b1;
    check({tag, "_words"}, got.size(), v.exp_words);
    compare_words(tag, e);
    check({tag, "_eop_data"}, (got.size() > 0) ? longint'(got[got.size()-1].data) : -1, v.exp_eop_data);
    check({tag, "_frame_count"}, frame_count, 16'(fc0 + 16'd1));
  endtask

  initial begin
    word_t       e[$];
    logic [15:0] fc0;

    vecs[0] = '{cols: 8,  rows: 4, x0: 2, y0: 1, w: 4, h: 2, d: 0, exp_words: 8,  exp_eop_data: 133};
    vecs[1] = '{cols: 16, rows: 8, x0: 0, y0: 0, w: 8, h: 4, d: 1, exp_words: 8,  exp_eop_data: 134};
    vecs[2] = '{cols: 8,  rows: 4, x0: 0, y0: 0, w: 8, h: 4, d: 0, exp_words: 32, exp_eop_data: 199};
    vecs[3] = '{cols: 16, rows: 8, x0: 4, y0: 4, w: 8, h: 4, d: 2, exp_words: 2,  exp_eop_data: 264};
    vecs[4] = '{cols: 16, rows: 8, x0: 8, y0: 0, w: 8, h: 8, d: 3, exp_words: 1,  exp_eop_data: 8};
    vecs[5] = '{cols: 8,  rows: 4, x0: 7, y0: 3, w: 1, h: 1, d: 0, exp_words: 1,  exp_eop_data: 199};

    reset_n = 1'b0; enable = 1'b1; cam_fval = 1'b0; cam_lval = 1'b0; cam_data = '0;
    clear_status = 1'b0; st_bus.st_ready = 1'b1;
    set_cfg(0, 0, 4, 2, 0);
    repeat (3) tick();
    check("rst_valid", st_bus.st_valid, 0);
    check("rst_sop", st_bus.st_sop, 0);
    check("rst_eop", st_bus.st_eop, 0);
    check("rst_data", st_bus.st_data, 0);
    check("rst_overflow", overflow, 0);
    check("rst_short", short_frame, 0);
    check("rst_frame_count", frame_count, 0);
    reset_n = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Overflow with a 4-deep FIFO, then a second frame arriving while in DROP.
    set_cfg(0, 0, 10, 1, 0);
    st_bus.st_ready = 1'b0;
    got.delete();
    fc0 = frame_count;
    frame(16, 2, 32);
    check("ovf_flag", overflow, 1);
    check("ovf_held_valid", st_bus.st_valid, 1);
    check("ovf_head_sop", st_bus.st_sop, 1);
    check("ovf_fc_before_drain", frame_count, fc0);
    frame(16, 2, 32);
    st_bus.st_ready = 1'b1;
    repeat (10) tick();
    e.delete();
    e.push_back('{sop: 1'b1, eop: 1'b0, data: 12'd0});
    e.push_back('{sop: 1'b0, eop: 1'b0, data: 12'd1});
    e.push_back('{sop: 1'b0, eop: 1'b0, data: 12'd2});
    e.push_back('{sop: 1'b0, eop: 1'b0, data: 12'd3});
    e.push_back('{sop: 1'b0, eop: 1'b1, data: 12'd0});
    check("ovf_pops", got.size(), 5);
    compare_words("ovf", e);
    check("ovf_fc_after_drain", frame_count, 16'(fc0 + 16'd1));
    clear_status = 1'b1; tick(); clear_status = 1'b0; tick();
    check("ovf_cleared", overflow, 0);

    // Short frame: 3 of 8 window pixels, then filler EOP.
    set_cfg(0, 0, 4, 2, 0);
    got.delete();
    fc0 = frame_count;
    frame(8, 4, 3);
    repeat (6) tick();
    e.delete();
    e.push_back('{sop: 1'b1, eop: 1'b0, data: 12'd0});
    e.push_back('{sop: 1'b0, eop: 1'b0, data: 12'd1});
    e.push_back('{sop: 1'b0, eop: 1'b0, data: 12'd2});
    e.push_back('{sop: 1'b0, eop: 1'b1, data: 12'd0});
    check("short_words", got.size(), 4);
    compare_words("short", e);
    check("short_flag", short_frame, 1);
    check("short_fc", frame_count, 16'(fc0 + 16'd1));
    clear_status = 1'b1; tick(); clear_status = 1'b0; tick();
    check("short_cleared", short_frame, 0);

    // Short frame before the window is reached: no packet, no flag.
    set_cfg(0, 2, 4, 1, 0);
    got.delete();
    fc0 = frame_count;
    frame(8, 4, 3);
    repeat (6) tick();
    check("short_empty_words", got.size(), 0);
    check("short_empty_flag", short_frame, 0);
    check("short_empty_fc", frame_count, fc0);

    // Mid-frame config change keeps the latched window.
    set_cfg(0, 0, 4, 2, 0);
    got.delete();
    fc0 = frame_count;
    fork
      frame(8, 4, 32);
      begin repeat (6) tick(); cfg_w = 12'd2; cfg_x0 = 12'd1; end
    join
    repeat (6) tick();
    check("latch_words", got.size(), 8);
    check("latch_eop_data", (got.size() > 0) ? longint'(got[got.size()-1].data) : -1, 67);
    check("latch_fc", frame_count, 16'(fc0 + 16'd1));

    // Enable low at frame start skips the frame even if raised later.
    set_cfg(0, 0, 4, 2, 0);
    enable = 1'b0;
    got.delete();
    fc0 = frame_count;
    fork
      frame(8, 4, 32);
      begin repeat (4) tick(); enable = 1'b1; end
    join
    repeat (6) tick();
    check("skip_words", got.size(), 0);
    check("skip_fc", frame_count, fc0);

    // Reset in the middle of a frame; the rest of that frame is ignored.
    set_cfg(0, 0, 8, 4, 0);
    fork
      frame(8, 4, 32);
      begin
        repeat (12) tick();
        reset_n = 1'b0;
        tick();
        check("midrst_valid", st_bus.st_valid, 0);
        check("midrst_fc", frame_count, 0);
        reset_n = 1'b1;
        got.delete();
      end
    join
    repeat (8) tick();
    check("midrst_tail_words", got.size(), 0);
    run_vec(vecs[2], "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
